// File: rtl/fp_alu_issuer.sv
// Command-side master for fp_alu_core: one op in flight, operands held through WAIT,
// response handed off over valid/ready with timeout, illegal-op rejection and sticky flags.
module fp_alu_issuer #(
   parameter int unsigned E       = 8,
   parameter int unsigned F       = 23,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [E+F:0]     cmd_a,
   input  logic [E+F:0]     cmd_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [E+F:0]     res_data,
   output logic [4:0]       res_flags,
   output logic [1:0]       res_status,
   output logic             alu_start,
   output logic [2:0]       alu_op_code,
   output logic [E+F:0]     alu_op_a,
   output logic [E+F:0]     alu_op_b,
   input  logic [E+F:0]     alu_result,
   input  logic [4:0]       alu_flags,
   input  logic             alu_valid_out,
   output logic [4:0]       sticky_flags,
   input  logic             sticky_clr,
   output logic             busy,
   output logic [15:0]      op_count
);

   localparam int unsigned W  = E + F + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   tcnt;
   logic            legal_c;
   logic            accept_c;
   logic            cap_ok_c;
   logic            cap_to_c;
   logic            resp_done_c;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake decode; valid_out only matters in WAIT, and beats the timeout
   always_comb begin
      state_nxt   = state;
      accept_c    = 1'b0;
      cap_ok_c    = 1'b0;
      cap_to_c    = 1'b0;
      resp_done_c = 1'b0;
      legal_c     = ~cmd_op[2];
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept_c  = 1'b1;
               state_nxt = legal_c ? ISSUE : RESP;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (alu_valid_out) begin
               cap_ok_c  = 1'b1;
               state_nxt = RESP;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               cap_to_c  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (res_ready) begin
               resp_done_c = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs, core command, response payload and counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         res_valid    <= 1'b0;
         alu_start    <= 1'b0;
         alu_op_code  <= 3'b000;
         alu_op_a     <= '0;
         alu_op_b     <= '0;
         res_data     <= '0;
         res_flags    <= '0;
         res_status   <= ST_OK;
         sticky_flags <= '0;
         op_count     <= '0;
         tcnt         <= '0;
      end else begin
         cmd_ready <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         res_valid <= (state_nxt == RESP);
         alu_start <= (state_nxt == ISSUE);

         if (accept_c && legal_c) begin
            alu_op_code <= cmd_op;
            alu_op_a    <= cmd_a;
            alu_op_b    <= cmd_b;
         end

         if (state == ISSUE)     tcnt <= '0;
         else if (state == WAIT) tcnt <= tcnt + TW'(1);

         if (accept_c && !legal_c) begin
            res_data   <= W'(0);
            res_flags  <= 5'd0;
            res_status <= ST_ILLEGAL;
         end else if (cap_ok_c) begin
            res_data   <= alu_result;
            res_flags  <= alu_flags;
            res_status <= ST_OK;
         end else if (cap_to_c) begin
            res_data   <= W'(0);
            res_flags  <= 5'd0;
            res_status <= ST_TIMEOUT;
         end

         // A capture in the same cycle as a clear leaves only the new flags
         if (cap_ok_c)        sticky_flags <= (sticky_clr ? 5'd0 : sticky_flags) | alu_flags;
         else if (sticky_clr) sticky_flags <= 5'd0;

         if (resp_done_c) op_count <= op_count + 16'd1;
      end
   end

endmodule
